// File: rtl/alu_seq_unit.sv
// Sequential ALU: operand A captured on the first Go edge, result computed on the second.
// Registered WIDTH+1-bit result with zero/carry flags, a result-valid pulse and one-hot state LEDs.
module alu_seq_unit #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          CHAIN_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Go,
  input  logic [2:0]       Opcode,
  input  logic [WIDTH-1:0] Data,
  output logic [WIDTH:0]   Alu_out,
  output logic             Flag_z,
  output logic             Flag_c,
  output logic             Res_vld,
  output logic             Led_idle,
  output logic             Led_wait,
  output logic             Led_rdy
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRdy
  } state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpShr = 3'b111;

  state_e           state_q, state_d;
  logic             go_q;
  logic             go_rise;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   alu_q, alu_d;
  logic [WIDTH:0]   alu_res;
  logic [WIDTH:0]   op_a, op_b;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             res_vld_q, res_vld_d;

  // go_q resets high so a Go held through reset does not look like an edge.
  assign go_rise = Go & ~go_q;

  assign op_a = {1'b0, a_q};
  assign op_b = {1'b0, Data};

  always_comb begin
    alu_res = '0;
    case (Opcode)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpNot:   alu_res = {1'b0, ~a_q};
      OpShl:   alu_res = {a_q, 1'b0};
      // Shifted-out bit lands in the carry position.
      OpShr:   alu_res = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    alu_d     = alu_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    res_vld_d = 1'b0;
    if (go_rise) begin
      case (state_q)
        StIdle: begin
          a_d     = Data;
          state_d = StWait;
        end
        StWait: begin
          alu_d     = alu_res;
          flag_z_d  = (alu_res[WIDTH-1:0] == '0);
          flag_c_d  = alu_res[WIDTH];
          res_vld_d = 1'b1;
          state_d   = StRdy;
        end
        StRdy: begin
          if (CHAIN_EN) begin
            a_d     = alu_q[WIDTH-1:0];
            state_d = StWait;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      go_q      <= 1'b1;
      a_q       <= '0;
      alu_q     <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= Go;
      a_q       <= a_d;
      alu_q     <= alu_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign Alu_out  = alu_q;
  assign Flag_z   = flag_z_q;
  assign Flag_c   = flag_c_q;
  assign Res_vld  = res_vld_q;
  assign Led_idle = (state_q == StIdle);
  assign Led_wait = (state_q == StWait);
  assign Led_rdy  = (state_q == StRdy);

  led_onehot_a: assert property (@(posedge clk) disable iff (rst)
    $onehot({Led_idle, Led_wait, Led_rdy}));

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: one plain and one accumulating instance, directed scenarios
// plus a randomized run, all checked against an arithmetic reference model.
module tb_alu_seq_unit;

  localparam int W = 4;
  typedef logic [W+6:0] vec_t;  // {out, z, c, vld, idle, wait, rdy}

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go0 = 1'b0, go1 = 1'b0;
  logic [2:0]   opcode = '0;
  logic [W-1:0] data = '0;

  logic [W:0] out0, out1;
  logic z0, z1, c0, c1, v0, v1, li0, li1, lw0, lw1, lr0, lr1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: state 0=IDLE 1=WAIT 2=RDY
  int m_st[2], m_a[2], m_out[2];
  bit m_z[2], m_c[2], m_v[2], m_gp[2];

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .CHAIN_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .Go(go0), .Opcode(opcode), .Data(data),
    .Alu_out(out0), .Flag_z(z0), .Flag_c(c0), .Res_vld(v0),
    .Led_idle(li0), .Led_wait(lw0), .Led_rdy(lr0)
  );

  alu_seq_unit #(.WIDTH(W), .CHAIN_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .Go(go1), .Opcode(opcode), .Data(data),
    .Alu_out(out1), .Flag_z(z1), .Flag_c(c1), .Res_vld(v1),
    .Led_idle(li1), .Led_wait(lw1), .Led_rdy(lr1)
  );

  function automatic int ref_op(int op, int a, int b);
    int modv = 1 << (W + 1);
    int full = 1 << W;
    case (op)
      0: return a + b;
      1: return (a - b + modv) % modv;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (full - 1) - a;
      6: return (a * 2) % modv;
      default: return a / 2 + (a % 2) * full;
    endcase
  endfunction

  task automatic model_tick(int u, bit go);
    bit rise;
    if (rst) begin
      m_st[u] = 0; m_a[u] = 0; m_out[u] = 0;
      m_z[u] = 0; m_c[u] = 0; m_v[u] = 0; m_gp[u] = 1;
      return;
    end
    rise = go && !m_gp[u];
    m_gp[u] = go;
    m_v[u] = 0;
    if (!rise) return;
    if (m_st[u] == 0) begin
      m_a[u] = int'(data);
      m_st[u] = 1;
    end else if (m_st[u] == 1) begin
      m_out[u] = ref_op(int'(opcode), m_a[u], int'(data));
      m_z[u] = (m_out[u] % (1 << W)) == 0;
      m_c[u] = (m_out[u] >> W) != 0;
      m_v[u] = 1;
      m_st[u] = 2;
    end else if (u == 1) begin
      m_a[u] = m_out[u] % (1 << W);
      m_st[u] = 1;
    end else begin
      m_st[u] = 0;
    end
  endtask

  function automatic vec_t exp_vec(int u);
    logic [W:0] o;
    o = (W+1)'(m_out[u]);
    return {o, m_z[u], m_c[u], m_v[u], m_st[u] == 0, m_st[u] == 1, m_st[u] == 2};
  endfunction

  function automatic vec_t obs_vec(int u);
    if (u == 0) return {out0, z0, c0, v0, li0, lw0, lr0};
    return {out1, z1, c1, v1, li1, lw1, lr1};
  endfunction

  task automatic step();
    model_tick(0, go0);
    model_tick(1, go1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_go(int u, logic v);
    if (u == 0) go0 = v;
    else go1 = v;
  endtask

  task automatic go_hi(int u, logic [W-1:0] d, logic [2:0] op);
    data = d;
    opcode = op;
    set_go(u, 1'b1);
    step();
  endtask

  task automatic go_lo(int u);
    set_go(u, 1'b0);
    step();
  endtask

  // Leaves unit u in RDY with Go still high on the computing edge.
  task automatic run_op(int u, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    go_hi(u, a, 3'($urandom));
    go_lo(u);
    go_hi(u, b, op);
  endtask

  task automatic ret_idle0();
    go_lo(0);
    go_hi(0, W'($urandom), 3'($urandom));
    go_lo(0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    vec_t idle_rst = {5'b00000, 3'b000, 3'b100};
    rst = 1'b1; go0 = 1'b1; go1 = 1'b1;
    step(); step();
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (obs_vec(u) !== idle_rst || exp_vec(u) !== idle_rst)
        $display("FAIL reset_state u%0d: got %b expected %b", u, obs_vec(u), idle_rst);
      else n_pass++;
    end
    rst = 1'b0;
    step(); step();
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (obs_vec(u) !== idle_rst)
        $display("FAIL reset_go_held u%0d: got %b expected %b", u, obs_vec(u), idle_rst);
      else n_pass++;
    end
    go0 = 1'b0; go1 = 1'b0;
    step();
  endtask

  task automatic test_add();
    vec_t e;
    go_hi(0, 4'b1001, 3'b101);
    n_checks++;
    if (obs_vec(0) !== exp_vec(0) || !lw0)
      $display("FAIL add_capture: got %b expected %b", obs_vec(0), exp_vec(0));
    else n_pass++;
    go_lo(0);
    go_hi(0, 4'b0111, 3'b000);
    e = {5'b10000, 3'b111, 3'b001};
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL add_result: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    go_lo(0);
    e = {5'b10000, 3'b110, 3'b001};
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL add_vld_pulse: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      data = W'($urandom);
      opcode = 3'($urandom);
      step();
    end
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL add_hold: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    go_hi(0, W'($urandom), 3'($urandom));
    e = {5'b10000, 3'b110, 3'b100};
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL rdy_to_idle: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    go_lo(0);
  endtask

  task automatic test_sub();
    vec_t e;
    run_op(0, 4'b0011, 4'b0101, 3'b001);
    e = {5'b11110, 3'b011, 3'b001};
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL sub_borrow: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    ret_idle0();
    run_op(0, 4'b0101, 4'b0011, 3'b001);
    e = {5'b00010, 3'b001, 3'b001};
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL sub_noborrow: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    ret_idle0();
  endtask

  task automatic test_logic_shift();
    logic [2:0] ops[4]  = '{3'b110, 3'b111, 3'b101, 3'b100};
    logic [4:0] outs[4] = '{5'b10110, 5'b10101, 5'b00100, 5'b00000};
    logic [1:0] zc[4]   = '{2'b01, 2'b01, 2'b00, 2'b10};
    vec_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(0, 4'b1011, (i == 3) ? 4'b1011 : W'($urandom), ops[i]);
      e = {outs[i], zc[i], 1'b1, 3'b001};
      n_checks++;
      if (obs_vec(0) !== e || obs_vec(0) !== exp_vec(0))
        $display("FAIL logic_shift op%b: got %b expected %b", ops[i], obs_vec(0), e);
      else n_pass++;
      ret_idle0();
    end
  endtask

  task automatic test_go_held();
    logic [W-1:0] a = W'($urandom);
    vec_t e;
    int bad = 0;
    go_hi(0, a, 3'($urandom));
    for (int i = 0; i < 10; i++) begin
      data = W'($urandom);
      step();
      if (!lw0 || li0 || lr0 || obs_vec(0) !== exp_vec(0)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL go_held_wait: got %0d bad cycles required 0", bad);
    else n_pass++;
    go_lo(0);
    go_hi(0, 4'b0000, 3'b000);
    e = {1'b0, a, a == 0, 1'b0, 1'b1, 3'b001};
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL go_held_capture: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    ret_idle0();
  endtask

  task automatic test_chain();
    vec_t e;
    pulse_reset();
    run_op(1, 4'b0011, 4'b0010, 3'b000);
    e = {5'b00101, 3'b001, 3'b001};
    n_checks++;
    if (obs_vec(1) !== e) $display("FAIL chain_first: got %b expected %b", obs_vec(1), e);
    else n_pass++;
    go_lo(1);
    go_hi(1, 4'b1111, 3'($urandom));
    e = {5'b00101, 3'b000, 3'b010};
    n_checks++;
    if (obs_vec(1) !== e) $display("FAIL chain_to_wait: got %b expected %b", obs_vec(1), e);
    else n_pass++;
    go_lo(1);
    go_hi(1, 4'b0001, 3'b000);
    e = {5'b00110, 3'b001, 3'b001};
    n_checks++;
    if (obs_vec(1) !== e) $display("FAIL chain_accum: got %b expected %b", obs_vec(1), e);
    else n_pass++;
    go_lo(1);
    go_hi(1, W'($urandom), 3'($urandom));
    go_lo(1);
    rst = 1'b1;
    step();
    e = {5'b00000, 3'b000, 3'b100};
    n_checks++;
    if (obs_vec(1) !== e) $display("FAIL chain_reset_wait: got %b expected %b", obs_vec(1), e);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_priority();
    vec_t e = {5'b00000, 3'b000, 3'b100};
    go0 = 1'b0;
    step();
    rst = 1'b1; go0 = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (obs_vec(0) !== e) $display("FAIL reset_priority: got %b expected %b", obs_vec(0), e);
    else n_pass++;
    go0 = 1'b0;
    step();
  endtask

  task automatic test_random();
    int bad[2] = '{0, 0};
    for (int i = 0; i < 400; i++) begin
      data = W'($urandom);
      opcode = 3'($urandom);
      if ($urandom_range(0, 2) == 0) go0 = ~go0;
      if ($urandom_range(0, 2) == 0) go1 = ~go1;
      rst = ($urandom_range(0, 39) == 0);
      step();
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (obs_vec(u) !== exp_vec(u)) begin
          if (bad[u] < 5)
            $display("FAIL random u%0d it%0d: got %b expected %b", u, i, obs_vec(u), exp_vec(u));
          bad[u]++;
        end else n_pass++;
      end
    end
    rst = 1'b0; go0 = 1'b0; go1 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_go_held();
    test_chain();
    test_reset_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
